// File: rtl/ir_proto_pkg.sv
// IR shot protocol constants and shared types for the shooter and the hit receiver.
package ir_proto_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2,
    ST_STUCK = 2'd3
  } ir_state_e;

  typedef struct packed {
    logic irq_en;
    logic enable;
  } ctrl_t;

  localparam logic [7:0] ADDR_DATA     = 8'h00;
  localparam logic [7:0] ADDR_CTRL     = 8'h04;
  localparam logic [7:0] ADDR_CLEAR    = 8'h08;
  localparam logic [7:0] ADDR_ERRCNT   = 8'h0C;
  localparam logic [7:0] ADDR_FRAMECNT = 8'h10;

  // Carrier timing in 100 MHz cycles, shared with the shooter side.
  localparam int unsigned CARRIER_PERIOD = 2633;
  localparam int unsigned CARRIER_HIGH   = 1974;
  localparam int unsigned PULSES_BIT0    = 7;
  localparam int unsigned PULSES_BIT1    = 19;
  localparam int unsigned BIT_GAP        = 40000;
  localparam int unsigned IR_NBITS       = 3;

  localparam int unsigned CNT_W   = 17;
  localparam int unsigned ERR_W   = 8;
  localparam int unsigned FRAME_W = 16;

endpackage

// File: rtl/ir_hit_receiver_if.sv
// APB register bus for the IR hit receiver.
interface ir_hit_receiver_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/ir_glitch_filter.sv
// Synchronizes the demodulator envelope and accepts a new level only after it is stable.
module ir_glitch_filter #(
  parameter int unsigned GLITCH = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ir_in,
  output logic o_ir_f
);

  localparam int unsigned GW = $clog2(GLITCH + 1);

  logic [1:0]    r_sync;
  logic [GW-1:0] r_cnt;
  logic          r_f;
  logic          w_mark;

  // Idle line is high, so the synchronizer resets to the no-carrier level.
  assign w_mark = ~r_sync[1];
  assign o_ir_f = r_f;

  // Two-flop synchronizer for the asynchronous envelope.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], i_ir_in};
  end

  // Flip the filtered level after GLITCH consecutive samples at the new level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_f   <= 1'b0;
    end else if (w_mark == r_f) begin
      r_cnt <= '0;
    end else if (r_cnt == GW'(GLITCH - 1)) begin
      r_f   <= w_mark;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + GW'(1);
    end
  end

endmodule

// File: rtl/ir_hit_receiver.sv
// IR shot frame decoder with APB register access and hit interrupt.
module ir_hit_receiver
  import ir_proto_pkg::*;
#(
  parameter int unsigned GLITCH      = 16,
  parameter int unsigned MIN_MARK    = 9000,
  parameter int unsigned ONE_THRESH  = 34000,
  parameter int unsigned MAX_MARK    = 80000,
  parameter int unsigned GAP_TIMEOUT = 120000,
  parameter int unsigned NBITS       = IR_NBITS
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  ir_hit_receiver_if.slave  apb,
  input  logic              ir_in,
  output logic              hit_irq
);

  localparam int unsigned BW = $clog2(NBITS + 1);

  logic               w_ir_f, r_f_d, w_rise, w_fall;
  logic [CNT_W-1:0]   r_cnt;
  ir_state_e          r_state, w_state_nxt;
  logic [BW-1:0]      r_bits, w_bits_nxt;
  logic [NBITS-1:0]   r_shift, w_shift_nxt, w_frame;
  logic               w_commit, w_err_inc;
  logic [NBITS-1:0]   r_data;
  logic               r_valid, r_ovr, w_valid_nxt, w_ovr_nxt;
  logic [FRAME_W-1:0] r_framecnt;
  logic [ERR_W-1:0]   r_errcnt;
  ctrl_t              r_ctrl, w_ctrl_nxt;
  logic               r_hit_irq;
  logic               w_wr, w_clr, w_err_clr;
  logic               w_unused;

  ir_glitch_filter #(.GLITCH(GLITCH)) u_filter (
    .i_clk   (PCLK),
    .i_rst_n (PRESETN),
    .i_ir_in (ir_in),
    .o_ir_f  (w_ir_f)
  );

  assign w_rise    = w_ir_f & ~r_f_d;
  assign w_fall    = ~w_ir_f & r_f_d;
  assign w_wr      = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign w_clr     = w_wr && (apb.PADDR == ADDR_CLEAR) && apb.PWDATA[0];
  assign w_err_clr = w_wr && (apb.PADDR == ADDR_ERRCNT);
  assign w_unused  = &{1'b0, apb.PWDATA[31:2]};

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;
  assign hit_irq     = r_hit_irq;

  // Saturating length counter, restarted on every filtered edge.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_cnt <= '0;
      r_f_d <= 1'b0;
    end else begin
      r_f_d <= w_ir_f;
      if (!r_ctrl.enable || w_rise || w_fall) r_cnt <= '0;
      else if (r_cnt != '1)                   r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Frame FSM state register.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state <= ST_IDLE;
      r_bits  <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bits  <= w_bits_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Frame FSM next state: classify marks, time out spaces, detect stuck carrier.
  always_comb begin
    w_state_nxt = r_state;
    w_bits_nxt  = r_bits;
    w_shift_nxt = r_shift;
    w_frame     = NBITS'({r_shift, (r_cnt >= CNT_W'(ONE_THRESH))});
    w_commit    = 1'b0;
    w_err_inc   = 1'b0;
    if (!r_ctrl.enable) begin
      w_state_nxt = ST_IDLE;
      w_bits_nxt  = '0;
      w_shift_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_rise) w_state_nxt = ST_MARK;
        ST_MARK: begin
          if (r_cnt >= CNT_W'(MAX_MARK)) begin
            w_err_inc   = 1'b1;
            w_state_nxt = ST_STUCK;
            w_bits_nxt  = '0;
            w_shift_nxt = '0;
          end else if (w_fall) begin
            if (r_cnt < CNT_W'(MIN_MARK)) begin
              w_err_inc   = 1'b1;
              w_state_nxt = ST_IDLE;
              w_bits_nxt  = '0;
              w_shift_nxt = '0;
            end else if (r_bits == BW'(NBITS - 1)) begin
              w_commit    = 1'b1;
              w_state_nxt = ST_IDLE;
              w_bits_nxt  = '0;
              w_shift_nxt = '0;
            end else begin
              w_state_nxt = ST_SPACE;
              w_bits_nxt  = r_bits + BW'(1);
              w_shift_nxt = w_frame;
            end
          end
        end
        ST_SPACE: begin
          if (w_rise) begin
            w_state_nxt = ST_MARK;
          end else if (r_cnt >= CNT_W'(GAP_TIMEOUT)) begin
            w_err_inc   = 1'b1;
            w_state_nxt = ST_IDLE;
            w_bits_nxt  = '0;
            w_shift_nxt = '0;
          end
        end
        ST_STUCK: if (!w_ir_f) w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Status next values: a commit beats a coincident CLEAR.
  always_comb begin
    w_ctrl_nxt  = r_ctrl;
    w_valid_nxt = r_valid;
    w_ovr_nxt   = r_ovr;
    if (w_wr && (apb.PADDR == ADDR_CTRL)) w_ctrl_nxt = ctrl_t'(apb.PWDATA[1:0]);
    if (w_clr) begin
      w_valid_nxt = 1'b0;
      w_ovr_nxt   = 1'b0;
    end
    if (w_commit) begin
      w_valid_nxt = 1'b1;
      w_ovr_nxt   = r_valid & ~w_clr;
    end
  end

  // Register file, counters and interrupt.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_ctrl     <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_ovr      <= 1'b0;
      r_framecnt <= '0;
      r_errcnt   <= '0;
      r_hit_irq  <= 1'b0;
    end else begin
      r_ctrl    <= w_ctrl_nxt;
      r_valid   <= w_valid_nxt;
      r_ovr     <= w_ovr_nxt;
      r_hit_irq <= w_valid_nxt & w_ctrl_nxt.irq_en;
      if (w_commit) begin
        r_data     <= w_frame;
        r_framecnt <= r_framecnt + FRAME_W'(1);
      end
      if (w_err_clr)                        r_errcnt <= '0;
      else if (w_err_inc && r_errcnt != '1) r_errcnt <= r_errcnt + ERR_W'(1);
    end
  end

  // Combinational APB read mux.
  always_comb begin
    apb.PRDATA = '0;
    if (apb.PSEL) begin
      case (apb.PADDR)
        ADDR_DATA:     apb.PRDATA = 32'({r_ovr, r_valid, 8'(r_data)});
        ADDR_CTRL:     apb.PRDATA = 32'({r_ctrl});
        ADDR_ERRCNT:   apb.PRDATA = 32'(r_errcnt);
        ADDR_FRAMECNT: apb.PRDATA = 32'(r_framecnt);
        default:       apb.PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_hit_receiver.sv
// Directed bench for ir_hit_receiver with time-scaled frame thresholds.
module tb_ir_hit_receiver;
  import ir_proto_pkg::*;

  localparam int unsigned T_ONE   = 500;
  localparam int unsigned T_ZERO  = 184;
  localparam int unsigned T_SPACE = 406;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ir_in = 1'b1;
  logic irq;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  ir_hit_receiver_if apb ();

  ir_hit_receiver #(
    .GLITCH(16), .MIN_MARK(90), .ONE_THRESH(340), .MAX_MARK(800),
    .GAP_TIMEOUT(1200), .NBITS(3)
  ) dut (
    .PCLK(clk), .PRESETN(rst_n), .apb(apb), .ir_in(ir_in), .hit_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    apb.PSEL = 1'b1; apb.PWRITE = 1'b0; apb.PENABLE = 1'b0; apb.PADDR = a;
    #1;
    check(tag, apb.PRDATA, exp);
    apb.PSEL = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    apb.PSEL = 1'b1; apb.PWRITE = 1'b1; apb.PADDR = a; apb.PWDATA = d; apb.PENABLE = 1'b0;
    @(negedge clk); apb.PENABLE = 1'b1;
    @(negedge clk); apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mark(input int unsigned n);
    ir_in = 1'b0;
    wait_cyc(n);
    ir_in = 1'b1;
  endtask

  task automatic frame(input logic [2:0] b);
    for (int i = 2; i >= 0; i--) begin
      mark(b[i] ? T_ONE : T_ZERO);
      wait_cyc(T_SPACE);
    end
  endtask

  initial begin
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = '0; apb.PWDATA = '0;
    wait_cyc(3);
    check("rst_irq", 32'(irq), 32'd0);
    rd("rst_data", ADDR_DATA, 32'h0);
    rd("rst_ctrl", ADDR_CTRL, 32'h0);
    rd("rst_errcnt", ADDR_ERRCNT, 32'h0);
    rd("rst_framecnt", ADDR_FRAMECNT, 32'h0);
    check("pready", 32'(apb.PREADY), 32'd1);
    check("pslverr", 32'(apb.PSLVERR), 32'd0);
    rst_n = 1'b1;
    wait_cyc(2);

    // Basic frame 1,0,1 with interrupt.
    wr(ADDR_CTRL, 32'h3);
    rd("ctrl_rw", ADDR_CTRL, 32'h3);
    frame(3'b101);
    rd("f101_data", ADDR_DATA, 32'h105);
    check("f101_irq", 32'(irq), 32'd1);
    rd("f101_framecnt", ADDR_FRAMECNT, 32'd1);
    apb.PADDR = ADDR_DATA; #1;
    check("psel0_prdata", apb.PRDATA, 32'h0);
    wr(ADDR_CLEAR, 32'h1);
    rd("clear_data", ADDR_DATA, 32'h005);
    check("clear_irq", 32'(irq), 32'd0);

    // Sub-glitch pulses are filtered out.
    repeat (5) begin
      ir_in = 1'b0; wait_cyc(10);
      ir_in = 1'b1; wait_cyc(30);
    end
    rd("glitch_errcnt", ADDR_ERRCNT, 32'd0);
    rd("glitch_data", ADDR_DATA, 32'h005);

    // Too-short mark is an error; next frame still decodes.
    mark(50); wait_cyc(T_SPACE);
    rd("short_errcnt", ADDR_ERRCNT, 32'd1);
    rd("short_data", ADDR_DATA, 32'h005);
    frame(3'b000);
    rd("f000_data", ADDR_DATA, 32'h100);
    rd("f000_framecnt", ADDR_FRAMECNT, 32'd2);

    // Gap timeout then stuck carrier.
    wr(ADDR_ERRCNT, 32'h0);
    rd("errcnt_wclr", ADDR_ERRCNT, 32'd0);
    wr(ADDR_CLEAR, 32'h1);
    mark(T_ONE); wait_cyc(T_SPACE); mark(T_ONE); wait_cyc(1500);
    rd("gap_errcnt", ADDR_ERRCNT, 32'd1);
    rd("gap_framecnt", ADDR_FRAMECNT, 32'd2);
    rd("gap_data", ADDR_DATA, 32'h000);
    ir_in = 1'b0; wait_cyc(1000);
    rd("stuck_errcnt", ADDR_ERRCNT, 32'd2);
    ir_in = 1'b1; wait_cyc(T_SPACE);
    rd("stuck_rel_errcnt", ADDR_ERRCNT, 32'd2);
    rd("stuck_rel_framecnt", ADDR_FRAMECNT, 32'd2);

    // Back-to-back frames set overrun.
    frame(3'b111);
    frame(3'b010);
    rd("ovr_data", ADDR_DATA, 32'h302);
    rd("ovr_framecnt", ADDR_FRAMECNT, 32'd4);

    // CLEAR landing on the commit cycle: commit wins, overrun cleared.
    mark(T_ONE); wait_cyc(T_SPACE);
    mark(T_ONE); wait_cyc(T_SPACE);
    mark(T_ZERO);
    wait_cyc(17);
    wr(ADDR_CLEAR, 32'h1);
    wait_cyc(50);
    rd("coinc_data", ADDR_DATA, 32'h106);
    rd("coinc_framecnt", ADDR_FRAMECNT, 32'd5);

    // Reset in the middle of a frame.
    mark(T_ONE); wait_cyc(T_SPACE); mark(T_ZERO); wait_cyc(200);
    rst_n = 1'b0;
    #1;
    check("mrst_irq", 32'(irq), 32'd0);
    rd("mrst_data", ADDR_DATA, 32'h0);
    rd("mrst_framecnt", ADDR_FRAMECNT, 32'h0);
    rd("mrst_ctrl", ADDR_CTRL, 32'h0);
    wait_cyc(3);
    rst_n = 1'b1;
    wr(ADDR_CTRL, 32'h3);
    frame(3'b110);
    rd("post_rst_data", ADDR_DATA, 32'h106);
    rd("post_rst_framecnt", ADDR_FRAMECNT, 32'd1);

    // Disable mid-frame drops the frame without an error.
    mark(T_ONE); wait_cyc(T_SPACE); mark(T_ONE); wait_cyc(200);
    wr(ADDR_CTRL, 32'h0);
    wait_cyc(200);
    mark(T_ZERO); wait_cyc(T_SPACE);
    rd("dis_framecnt", ADDR_FRAMECNT, 32'd1);
    rd("dis_errcnt", ADDR_ERRCNT, 32'd0);
    rd("dis_data", ADDR_DATA, 32'h106);
    check("dis_irq", 32'(irq), 32'd0);
    wr(ADDR_CTRL, 32'h3);
    frame(3'b011);
    rd("reen_data", ADDR_DATA, 32'h303);
    rd("reen_framecnt", ADDR_FRAMECNT, 32'd2);
    check("reen_irq", 32'(irq), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
